pipeline_trace_buffer: RTL and testbench

Parametrised successor to the passive pipeline info-bus debugger. It captures packed per-instruction info records into a circular history buffer, triggers on a PC match or an external strobe, and keeps a fixed number of post-trigger records. After capture it freezes and streams the history out oldest-first over a valid/ready port. It sits beside the writeback stage and takes the same packed info bus that stage carries.

---
 rtl/pipeline_trace_buffer_if.sv | 34 +++
 rtl/pipeline_trace_buffer.sv | 168 ++++++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_trace_buffer_if.sv
// rtl/pipeline_trace_buffer_if.sv - capture and readout bus bundle for the trace buffer
//
// Purpose: groups the writeback-side info bus and the history readout stream
// so the trace buffer and its consumer share one connection.
// Signals:
//   info_in / info_valid : packed record and its retired-instruction qualifier
//   rd_valid / rd_ready  : readout handshake
//   rd_data              : record at the readout pointer
// Modports: master drives the info bus and rd_ready; slave is the trace buffer.
interface pipeline_trace_buffer_if #(
  parameter int INFO_W = 256
);
  logic [INFO_W-1:0] info_in;
  logic              info_valid;
  logic              rd_valid;
  logic              rd_ready;
  logic [INFO_W-1:0] rd_data;

  modport master (
    output info_in,
    output info_valid,
    output rd_ready,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  info_in,
    input  info_valid,
    input  rd_ready,
    output rd_valid,
    output rd_data
  );
endinterface

// File: rtl/pipeline_trace_buffer.sv
// rtl/pipeline_trace_buffer.sv - triggered circular history of pipeline info records
//
// Purpose: captures retired-instruction records into a circular buffer while
// armed, triggers on a PC match or an external strobe, keeps POST_TRIG more
// records, then freezes and streams the history out oldest-first.
// Ports:
//   clk, reset  : clock and asynchronous active-low reset
//   arm         : start or restart a capture (wins over everything else)
//   trig_en/pc  : PC-match trigger enable and value
//   ext_trig    : external trigger strobe, only honoured with a valid record
//   bus         : info capture input and readout stream (slave modport)
//   trig_idx    : readout position of the trigger record
//   count       : records held (saturates at DEPTH)
//   overflow    : older records were overwritten
//   state       : 0=IDLE 1=ARMED 2=POST 3=DONE
module pipeline_trace_buffer #(
  parameter int INFO_W    = 256,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int PC_LSB    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       trig_en,
  input  logic [31:0]                trig_pc,
  input  logic                       ext_trig,
  pipeline_trace_buffer_if.slave     bus,
  output logic [$clog2(DEPTH)-1:0]   trig_idx,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [1:0]                 state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [INFO_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     post_cnt_q, post_cnt_d;
  logic [AW-1:0]     trig_idx_q, trig_idx_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     remaining_q, remaining_d;
  logic              overflow_q, overflow_d;
  logic              capture, pc_hit, trigger, rd_fire;

  // arm suppresses the capture on its own edge so a restart starts empty.
  assign capture = !arm && bus.info_valid && (state_q == S_ARMED || state_q == S_POST);
  assign pc_hit  = trig_en && (bus.info_in[PC_LSB +: 32] == trig_pc);
  assign trigger = capture && (state_q == S_ARMED) && (ext_trig || pc_hit);

  assign bus.rd_valid = (state_q == S_DONE) && (remaining_q != '0);
  assign bus.rd_data  = mem_q[rd_ptr_q];
  assign rd_fire      = bus.rd_valid && bus.rd_ready;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    post_cnt_d  = post_cnt_q;
    trig_idx_d  = trig_idx_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    overflow_d  = overflow_q;

    if (arm) begin
      state_d     = S_ARMED;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      post_cnt_d  = '0;
      trig_idx_d  = '0;
      count_d     = '0;
      remaining_d = '0;
      overflow_d  = 1'b0;
    end else begin
      if (capture) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (count_q == CW'(DEPTH)) begin
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      case (state_q)
        S_ARMED: begin
          if (trigger) begin
            if (POST_TRIG == 0) begin
              state_d = S_DONE;
            end else begin
              state_d    = S_POST;
              post_cnt_d = AW'(POST_TRIG);
            end
          end
        end
        S_POST: begin
          if (capture) begin
            post_cnt_d = post_cnt_q - 1'b1;
            if (post_cnt_q == AW'(1)) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (rd_fire) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == CW'(1)) begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin
        end
      endcase

      // Freeze point: the oldest surviving record sits count entries behind
      // the post-capture write pointer; a full buffer wraps to wr_ptr itself.
      if (state_d == S_DONE && state_q != S_DONE) begin
        rd_ptr_d    = wr_ptr_d - count_d[AW-1:0];
        remaining_d = count_d;
        trig_idx_d  = AW'(count_d - CW'(1) - CW'(POST_TRIG));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      post_cnt_q  <= '0;
      trig_idx_q  <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      post_cnt_q  <= post_cnt_d;
      trig_idx_q  <= trig_idx_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      overflow_q  <= overflow_d;
    end
  end

  // History storage needs no reset; stale contents are never read out.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_q[wr_ptr_q] <= bus.info_in;
    end
  end

  assign trig_idx = trig_idx_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign state    = state_q;
endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// tb/tb_pipeline_trace_buffer.sv - self-checking bench for pipeline_trace_buffer
module tb_pipeline_trace_buffer;
  localparam int INFO_W    = 64;
  localparam int DEPTH     = 8;
  localparam int POST_TRIG = 3;
  localparam int PC_LSB    = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        ext_trig = 1'b0;
  logic [2:0]  trig_idx;
  logic [3:0]  count;
  logic        overflow;
  logic [1:0]  state;

  pipeline_trace_buffer_if #(.INFO_W(INFO_W)) bus ();

  pipeline_trace_buffer #(
    .INFO_W(INFO_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .PC_LSB(PC_LSB)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .ext_trig(ext_trig), .bus(bus), .trig_idx(trig_idx), .count(count),
    .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the held history is just a bounded queue of records.
  logic [63:0] m_q[$];
  logic        m_ovf = 1'b0;
  int          m_phase = 0;
  int          m_post = 0;
  logic [63:0] exp_q[$];
  logic [63:0] fed [20];

  typedef struct {
    logic [31:0] tpc;
    int          cnt;
    logic        ovf;
    int          tidx;
    int          first_k;
  } vec_t;
  vec_t vecs [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic m_step(input logic v, input logic [63:0] rec, input logic ext);
    if ((m_phase == 1 || m_phase == 2) && v) begin
      if (m_q.size() == DEPTH) begin
        void'(m_q.pop_front());
        m_ovf = 1'b1;
      end
      m_q.push_back(rec);
      if (m_phase == 1) begin
        if (ext || (trig_en && rec[31:0] == trig_pc)) begin
          if (POST_TRIG == 0) m_phase = 3;
          else begin
            m_phase = 2;
            m_post  = POST_TRIG;
          end
        end
      end else begin
        m_post--;
        if (m_post == 0) m_phase = 3;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [63:0] rec, input logic ext);
    bus.info_valid = v;
    bus.info_in    = rec;
    ext_trig       = ext;
    @(posedge clk);
    m_step(v, rec, ext);
    #1;
    chk("state", 64'(state), 64'(m_phase));
    chk("count", 64'(count), 64'(m_q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    bus.info_valid = 1'b0;
    ext_trig       = 1'b0;
  endtask

  task automatic do_arm(input logic v, input logic [63:0] rec);
    arm            = 1'b1;
    bus.info_valid = v;
    bus.info_in    = rec;
    @(posedge clk);
    m_q.delete();
    m_ovf   = 1'b0;
    m_phase = 1;
    #1;
    arm            = 1'b0;
    bus.info_valid = 1'b0;
    chk("arm_state", 64'(state), 64'd1);
    chk("arm_count", 64'(count), 64'd0);
    chk("arm_overflow", 64'(overflow), 64'd0);
  endtask

  task automatic fill_fed();
    for (int k = 0; k < 20; k++) fed[k] = {$urandom, 32'h3000 + 32'(4 * k)};
  endtask

  task automatic run_stream(input logic [31:0] tpc);
    fill_fed();
    trig_en = 1'b1;
    trig_pc = tpc;
    do_arm(1'b0, '0);
    for (int k = 0; k < 20; k++) cyc(1'b1, fed[k], 1'b0);
  endtask

  task automatic readout(input int mode, input string tag);
    int          i;
    logic [63:0] held;
    logic        stalled;
    i = 0;
    held = '0;
    stalled = 1'b0;
    for (int c = 0; c < 200 && state == 2'd3; c++) begin
      case (mode)
        0:       bus.rd_ready = 1'b1;
        1:       bus.rd_ready = (c % 4 == 0) || (c % 4 == 3);
        default: bus.rd_ready = 1'($urandom_range(0, 1));
      endcase
      chk({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'd1);
      if (stalled) chk({tag, "_rd_stable"}, bus.rd_data, held);
      if (i < exp_q.size()) chk({tag, "_rd_data"}, bus.rd_data, exp_q[i]);
      held    = bus.rd_data;
      stalled = !bus.rd_ready;
      @(posedge clk);
      #1;
      if (bus.rd_ready) i++;
    end
    bus.rd_ready = 1'b0;
    chk({tag, "_handshakes"}, 64'(i), 64'(exp_q.size()));
    chk({tag, "_end_state"}, 64'(state), 64'd0);
    chk({tag, "_end_rd_valid"}, 64'(bus.rd_valid), 64'd0);
    m_phase = 0;
  endtask

  task automatic random_runs();
    logic        v;
    logic [63:0] rec;
    for (int r = 0; r < 8; r++) begin
      trig_en = 1'($urandom_range(0, 1));
      trig_pc = 32'h3000 + 32'(4 * $urandom_range(0, 15));
      do_arm(1'b0, '0);
      for (int c = 0; c < 150 && m_phase != 3; c++) begin
        v   = ($urandom_range(0, 3) != 0);
        rec = {$urandom, 32'h3000 + 32'(4 * $urandom_range(0, 15))};
        cyc(v, rec, $urandom_range(0, 19) == 0);
      end
      if (m_phase == 3) begin
        chk("rand_trig_idx", 64'(trig_idx), 64'((m_q.size() - 1 - POST_TRIG) % DEPTH));
        exp_q = m_q;
        readout(2, "rand");
      end
    end
  endtask

  initial begin
    vecs[0] = '{tpc: 32'h3020, cnt: 8, ovf: 1'b1, tidx: 4, first_k: 4};
    vecs[1] = '{tpc: 32'h3004, cnt: 5, ovf: 1'b0, tidx: 1, first_k: 0};

    bus.info_in    = '0;
    bus.info_valid = 1'b0;
    bus.rd_ready   = 1'b0;

    // Reset state, then idle with no arm ignores traffic and triggers
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_trig_idx", 64'(trig_idx), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    reset = 1'b1;
    fill_fed();
    for (int k = 0; k < 4; k++) cyc(1'b1, fed[k], 1'b1);

    // Table: wrap and early trigger on PC match
    for (int t = 0; t < 2; t++) begin
      run_stream(vecs[t].tpc);
      chk("tab_state", 64'(state), 64'd3);
      chk("tab_count", 64'(count), 64'(vecs[t].cnt));
      chk("tab_overflow", 64'(overflow), 64'(vecs[t].ovf));
      chk("tab_trig_idx", 64'(trig_idx), 64'(vecs[t].tidx));
      exp_q.delete();
      for (int i = 0; i < vecs[t].cnt; i++) exp_q.push_back(fed[vecs[t].first_k + i]);
      readout(0, "tab");
      chk("tab_count_hold", 64'(count), 64'(vecs[t].cnt));
      chk("tab_trig_idx_hold", 64'(trig_idx), 64'(vecs[t].tidx));
    end

    // Bubbles and ext_trig: trigger on a bubble is ignored
    fill_fed();
    trig_en = 1'b0;
    do_arm(1'b0, '0);
    cyc(1'b1, fed[0], 1'b0);
    cyc(1'b1, fed[1], 1'b0);
    cyc(1'b0, 64'h0000_0BAD_0000_3008, 1'b1);
    chk("bubble_trig_ignored", 64'(state), 64'd1);
    cyc(1'b1, fed[2], 1'b1);
    chk("ext_trig_taken", 64'(state), 64'd2);
    cyc(1'b0, 64'h0000_0BAD_0000_300C, 1'b0);
    cyc(1'b1, fed[3], 1'b0);
    cyc(1'b0, 64'h0000_0BAD_0000_3010, 1'b1);
    cyc(1'b1, fed[4], 1'b0);
    cyc(1'b1, fed[5], 1'b0);
    chk("gap_state", 64'(state), 64'd3);
    chk("gap_count", 64'(count), 64'd6);
    chk("gap_trig_idx", 64'(trig_idx), 64'd2);
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(fed[i]);
    readout(0, "gap");

    // Backpressure 1,0,0,1 on the wrapped capture
    run_stream(32'h3020);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(fed[4 + i]);
    readout(1, "bp");

    // Abort during POST; the arm edge's valid record is not captured
    fill_fed();
    trig_en = 1'b1;
    trig_pc = 32'h3004;
    do_arm(1'b0, '0);
    for (int k = 0; k < 3; k++) cyc(1'b1, fed[k], 1'b0);
    chk("abort_in_post", 64'(state), 64'd2);
    do_arm(1'b1, fed[3]);
    trig_en = 1'b0;
    cyc(1'b1, fed[4], 1'b1);
    for (int k = 5; k < 8; k++) cyc(1'b1, fed[k], 1'b0);
    chk("abort_count", 64'(count), 64'd4);
    chk("abort_trig_idx", 64'(trig_idx), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(fed[4 + i]);
    readout(0, "abort");

    // Asynchronous reset in the middle of readout
    run_stream(32'h3004);
    bus.rd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("mid_rst_state", 64'(state), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    bus.rd_ready = 1'b0;
    m_q.delete();
    m_ovf   = 1'b0;
    m_phase = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) cyc(1'b1, fed[k], 1'b1);

    random_runs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
